// File: rtl/systolic_matmul_nxn_pkg.sv
// Shared types and helpers for the NxN output-stationary systolic multiplier.
// SYSTOLIC_SATURATE_EN selects saturating accumulation in the PE.
package systolic_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUTPUT} state_t;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 40;

    // Zero-injection cycles needed to flush the last beat through the skewed array.
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

    // From the sign bits of the two addends and their sum:
    // bit0 = positive overflow, bit1 = negative overflow.
    function automatic logic [1:0] sat_sel(input logic sa, input logic sb, input logic ss);
        return {sa & sb & ~ss, ~sa & ~sb & ss};
    endfunction

endpackage

// File: rtl/systolic_matmul_nxn_pe.sv
// One MAC cell: a flows right, b flows down, acc is output-stationary.
// SYSTOLIC_SATURATE_EN clamps the accumulator instead of wrapping.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [AW-1:0] acc
);

    logic [DW-1:0]          a_q, b_q;
    logic [AW-1:0]          acc_q, acc_d, base, pext, sum;
    logic signed [2*DW-1:0] prod;

    always_comb begin
        prod  = $signed(a_in) * $signed(b_in);
        pext  = AW'(prod);
        base  = clr ? '0 : acc_q;
        sum   = base + pext;
        acc_d = acc_q;
        if (en) begin
`ifdef SYSTOLIC_SATURATE_EN
            case (sat_sel(base[AW-1], pext[AW-1], sum[AW-1]))
                2'b01:   acc_d = {1'b0, {(AW-1){1'b1}}};
                2'b10:   acc_d = {1'b1, {(AW-1){1'b0}}};
                default: acc_d = sum;
            endcase
`else
            acc_d = sum;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
            if (en) begin
                a_q <= a_in;
                b_q <= b_in;
            end
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/systolic_matmul_nxn.sv
// NxN output-stationary systolic matmul with input skew, drain FSM and row-serial output.
// Define SYSTOLIC_SATURATE_EN for saturating accumulators (default: wrap).
module systolic_matmul_nxn
    import systolic_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [N*DW-1:0]      a_col,
    input  logic [N*DW-1:0]      b_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*AW-1:0]      out_data,
    output logic [$clog2(N)-1:0] out_row,
    output logic                 out_last,
    output logic                 busy
);

    localparam int RW   = $clog2(N);
    localparam int CW   = $clog2(2 * N);
    localparam int DLEN = drain_len(N);

    logic [N-1:0][N:0][DW-1:0]  a_h;
    logic [N:0][N-1:0][DW-1:0]  b_v;
    logic [N-1:0][N-1:0][AW-1:0] acc_w;
    logic [N-1:0][DW-1:0]       a_inj, b_inj;

    state_t          state_q, state_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            in_ready_q, in_ready_d, busy_q, busy_d;
    logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [N*AW-1:0] out_data_q, out_data_d, row_sel;
    logic [RW-1:0]   out_row_q, out_row_d, nxt_row;
    logic            accept, adv, clr, draining;

    assign accept   = in_valid && in_ready_q;
    assign draining = (state_q == S_DRAIN);
    assign adv      = accept || draining;
    assign clr      = accept && (state_q == S_IDLE);

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_inj[i] = draining ? '0 : a_col[i*DW +: DW];
            b_inj[i] = draining ? '0 : b_row[i*DW +: DW];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_edge
        if (g == 0) begin : g_direct
            assign a_h[0][0] = a_inj[0];
            assign b_v[0][0] = b_inj[0];
        end else begin : g_skew
            // Row/column g is delayed g stages; the chain only moves with the array.
            logic [DW-1:0] ska_q [g];
            logic [DW-1:0] skb_q [g];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < g; s++) begin
                        ska_q[s] <= '0;
                        skb_q[s] <= '0;
                    end
                end else if (adv) begin
                    ska_q[0] <= a_inj[g];
                    skb_q[0] <= b_inj[g];
                    for (int s = 1; s < g; s++) begin
                        ska_q[s] <= ska_q[s-1];
                        skb_q[s] <= skb_q[s-1];
                    end
                end
            end
            assign a_h[g][0] = ska_q[g-1];
            assign b_v[0][g] = skb_q[g-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .en    (adv),
                .clr   (clr),
                .a_in  (a_h[i][j]),
                .b_in  (b_v[i][j]),
                .a_out (a_h[i][j+1]),
                .b_out (b_v[i+1][j]),
                .acc   (acc_w[i][j])
            );
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_last_d  = out_last_q;
        nxt_row     = out_valid_q ? out_row_q + RW'(1) : '0;
        for (int j = 0; j < N; j++) row_sel[j*AW +: AW] = acc_w[nxt_row][j];
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    drain_cnt_d = '0;
                    state_d     = in_last ? S_DRAIN : S_LOAD;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == CW'(DLEN - 1)) state_d = S_OUTPUT;
                else drain_cnt_d = drain_cnt_q + CW'(1);
            end
            S_OUTPUT: begin
                // First cycle loads row 0; thereafter each accepted row loads the next.
                if (!out_valid_q || out_ready) begin
                    if (out_valid_q && out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        out_valid_d = 1'b1;
                        out_row_d   = nxt_row;
                        out_data_d  = row_sel;
                        out_last_d  = (nxt_row == RW'(N - 1));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Directed/random bench for systolic_matmul_nxn (N=4) against a plain-arithmetic matmul model.
// Build with SYSTOLIC_SATURATE_EN to check the saturating variant.
module tb_systolic_matmul_nxn;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int AW   = 40;
    localparam int KMAX = 600;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic            in_ready, out_valid, out_last, busy;
    logic [N*DW-1:0] a_col = '0, b_row = '0;
    logic [N*AW-1:0] out_data;
    logic [1:0]      out_row;

    systolic_matmul_nxn #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     am [N][KMAX];
    int     bm [KMAX][N];
    longint exp_c [N][N];

    function automatic longint fix(input longint x);
`ifdef SYSTOLIC_SATURATE_EN
        longint mx = (longint'(1) <<< (AW - 1)) - 1;
        longint mn = -(longint'(1) <<< (AW - 1));
        if (x > mx) return mx;
        if (x < mn) return mn;
        return x;
`else
        return (x <<< (64 - AW)) >>> (64 - AW);
`endif
    endfunction

    task automatic chk(input string tag, input logic [N*AW-1:0] obs, input logic [N*AW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [N*AW-1:0] row_exp(input int r);
        logic [N*AW-1:0] v;
        longint t;
        for (int j = 0; j < N; j++) begin
            t = exp_c[r][j];
            v[j*AW +: AW] = t[AW-1:0];
        end
        return v;
    endfunction

    task automatic fill_zero(input int k_n);
        for (int k = 0; k < k_n; k++)
            for (int i = 0; i < N; i++) begin
                am[i][k] = 0;
                bm[k][i] = 0;
            end
    endtask

    task automatic fill_rand(input int k_n, input int lim);
        for (int k = 0; k < k_n; k++)
            for (int i = 0; i < N; i++) begin
                am[i][k] = int'($urandom_range(0, 2 * lim - 1)) - lim;
                bm[k][i] = int'($urandom_range(0, 2 * lim - 1)) - lim;
            end
    endtask

    // Computes the reference result, then streams K beats with `gap` idle cycles between them.
    task automatic send_beats(input int k_n, input int gap);
        logic [N*DW-1:0] av, bv;
        int t;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                exp_c[i][j] = 0;
                for (int k = 0; k < k_n; k++)
                    exp_c[i][j] = fix(exp_c[i][j] + longint'(am[i][k]) * longint'(bm[k][j]));
            end
        for (int k = 0; k < k_n; k++) begin
            for (int i = 0; i < N; i++) begin
                t = am[i][k]; av[i*DW +: DW] = t[DW-1:0];
                t = bm[k][i]; bv[i*DW +: DW] = t[DW-1:0];
            end
            in_valid = 1'b1; a_col = av; b_row = bv; in_last = (k == k_n - 1);
            @(negedge clk);
            chk("in_ready_beat", in_ready, 1'b1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (k != k_n - 1) begin
                repeat (gap) begin
                    a_col = {$urandom, $urandom}; b_row = {$urandom, $urandom}; in_last = 1'b1;
                    @(posedge clk); #1;
                end
                in_last = 1'b0;
            end
        end
    endtask

    task automatic wait_out(input bit garbage);
        int lat = 0;
        for (int l = 1; l <= 64; l++) begin
            if (garbage) begin
                in_valid = 1'b1; in_last = 1'($urandom);
                a_col = {$urandom, $urandom}; b_row = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            if (l == 2) begin
                chk("drain_busy", busy, 1'b1);
                chk("drain_in_ready", in_ready, 1'b0);
            end
            if (out_valid) begin
                lat = l;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("latency", lat, 2 * N);
    endtask

    task automatic collect(input int bp_row, input int bp_cyc);
        for (int r = 0; r < N; r++) begin
            if (r == bp_row) begin
                out_ready = 1'b0;
                repeat (bp_cyc) begin
                    @(posedge clk); #1;
                    chk("bp_valid", out_valid, 1'b1);
                    chk("bp_data", out_data, row_exp(r));
                    chk("bp_row", out_row, r);
                end
                out_ready = 1'b1;
            end
            chk("row_valid", out_valid, 1'b1);
            chk("row_data", out_data, row_exp(r));
            chk("row_idx", out_row, r);
            chk("row_last", out_last, r == N - 1);
            @(posedge clk); #1;
        end
        chk("done_valid", out_valid, 1'b0);
        chk("done_busy", busy, 1'b0);
        chk("done_in_ready", in_ready, 1'b1);
    endtask

    task automatic run(input int k_n, input int gap, input bit garbage, input int bp_row, input int bp_cyc);
        send_beats(k_n, gap);
        wait_out(garbage);
        collect(bp_row, bp_cyc);
    endtask

    initial begin
        int rises;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_row", out_row, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // 2x2 example embedded in the top-left corner
        fill_zero(2);
        am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
        bm[0][0] = 5; bm[0][1] = 6; bm[1][0] = 7; bm[1][1] = 8;
        run(2, 0, 1'b0, -1, 0);
        chk("basic_c00", exp_c[0][0][AW-1:0], AW'(19));
        chk("basic_c11", exp_c[1][1][AW-1:0], AW'(50));

        // identity x (1..16) with bubbles between beats
        fill_zero(N);
        for (int i = 0; i < N; i++) begin
            am[i][i] = 1;
            for (int j = 0; j < N; j++) bm[i][j] = i * N + j + 1;
        end
        run(N, 3, 1'b0, -1, 0);

        // K=1 straight from IDLE, in_valid noise during drain
        fill_rand(1, 100);
        am[0][0] = 2; am[1][0] = -3; bm[0][0] = 4; bm[0][1] = 5;
        run(1, 0, 1'b1, -1, 0);

        // output backpressure on row 2, then a fresh back-to-back matrix
        fill_rand(7, 32768);
        run(7, 0, 1'b0, 2, 5);
        fill_rand(5, 32768);
        run(5, 1, 1'b0, -1, 0);

        // async reset in the middle of DRAIN
        fill_rand(3, 1000);
        send_beats(3, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        @(negedge clk) rst = 1'b0;
        rises = 0;
        repeat (3 * N) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        chk("midrst_no_rows", rises, 0);
        fill_rand(4, 32768);
        run(4, 2, 1'b0, -1, 0);

        // accumulator overflow: 520 * 2^30 exceeds the 40-bit signed range
        for (int k = 0; k < 520; k++)
            for (int i = 0; i < N; i++) begin
                am[i][k] = -32768;
                bm[k][i] = -32768;
            end
        run(520, 0, 1'b0, -1, 0);

        for (int n = 0; n < 3; n++) begin
            int kk = int'($urandom_range(1, 10));
            fill_rand(kk, 32768);
            run(kk, int'($urandom_range(0, 2)), 1'b1, int'($urandom_range(0, N - 1)), int'($urandom_range(1, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_matmul_nxn.md
Name: systolic_matmul_nxn

Overview:
Parametrised output-stationary systolic matrix multiplier, successor to the fixed 2x2 array. Computes C = A x B, where A is NxK and B is KxN, with signed operands. K is set at run time by an in_last marker. Operands stream in one beat per inner index k with valid/ready handshaking. Results drain out one row of C per beat through a second valid/ready handshake. The block sits between an operand fetch unit and a result writeback unit.

Parameters:
N, 4, array dimension (NxN PEs); legal 2..8
DW, 16, signed operand width
AW, 40, signed accumulator/result width; must be >= 2*DW

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts operand beat
in_last  input  1  marks beat k = K-1
a_col  input  N*DW  column k of A; element i (A[i][k]) at [i*DW +: DW]
b_row  input  N*DW  row k of B; element j (B[k][j]) at [j*DW +: DW]
out_valid  output  1  result row valid
out_ready  input  1  downstream accepts result row
out_data  output  N*AW  row r of C; C[r][j] at [j*AW +: AW]
out_row  output  $clog2(N)  row index r of out_data
out_last  output  1  high with row N-1
busy  output  1  high in LOAD, DRAIN and OUTPUT

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_row=0, out_last=0, busy=0. All PE accumulators, skew registers and pipeline registers are cleared. The FSM enters IDLE.
- Reset is asynchronous at any time, including mid-LOAD, DRAIN or OUTPUT. The in-flight matrix is discarded; there is no partial output.
- FSM states: IDLE, LOAD, DRAIN, OUTPUT.
- IDLE: in_ready=1. An accepted beat (in_valid && in_ready) clears all accumulators in the same edge and injects that beat. Next state is LOAD, or DRAIN if in_last is also set (K=1 is legal).
- LOAD: in_ready=1. The array, including skew registers, advances only on an accepted beat; when in_valid=0 the whole array stalls, so bubbles do not corrupt alignment. An accepted beat with in_last moves the FSM to DRAIN.
- DRAIN: in_ready=0. The array free-runs with zeros injected on both edges for 2N-1 cycles, counted by a drain counter.
- Latency: out_valid first rises exactly 2N clk edges after the edge that accepted the in_last beat.
- Skew: row i of the A input is delayed i stages and column j of the B input is delayed j stages before entering the array. PE(i,j) passes a rightward and b downward, one register stage each.
- PE arithmetic: acc += sext(a)*sext(b), computed as a 2*DW-bit signed product, sign-extended to AW, two's complement wrap on overflow.
- OUTPUT: in_ready=0. Rows are presented in order r=0..N-1. out_data, out_row and out_last are held stable while out_valid && !out_ready. A row advances on out_valid && out_ready.
- Leaving OUTPUT: after row N-1 is accepted, out_valid drops on the next edge and the FSM returns to IDLE.
- Back-to-back matrices: a new matrix can be accepted on the cycle after the FSM returns to IDLE.
- Ignored inputs: in_valid asserted while in_ready=0 is ignored, with no side effect. in_last is ignored when in_valid is low.

Optional Feature:
- Macro: SYSTOLIC_SATURATE_EN.
- Defined: each accumulate saturates to the AW-bit signed range, min -2^(AW-1), max 2^(AW-1)-1. Overflow cannot re-wrap once saturated.
- Undefined: two's complement wrap, as specified above.

Decomposition:
- Package systolic_pkg holds:
  - the FSM state typedef (IDLE/LOAD/DRAIN/OUTPUT)
  - the default DW/AW constants
  - a function giving the drain length 2N-1
  - the saturating-add helper used under SYSTOLIC_SATURATE_EN
- One sub-module, systolic_pe: one MAC cell with a/b pass-through registers, an enable (array advance), a clear, and an accumulator output. The top level instantiates it in an NxN generate loop alongside the skew registers, FSM and output row mux.

Test Plan:
- Basic multiply, N=2, DW=16: A=[[1,2],[3,4]], B=[[5,6],[7,8]] sent as 2 beats, beat 1 with in_last. Expect row0 = {19,22}, row1 = {43,50}; out_last on row 1; out_valid first rises 4 edges after the last beat.
- Input bubbles, N=4: A = identity, B holding 1..16, in_valid deasserted for 3 cycles between every beat. Expect C = B, identical to the gap-free run.
- K=1 from IDLE, N=2: a single beat with in_last, a_col={2,-3}, b_row={4,5}. Expect C=[[8,10],[-12,-15]].
- Output backpressure, N=4: out_ready low for 5 cycles on row 2. Expect row 2 data and out_row to stay stable, rows emitted in order, no row lost or duplicated; a second matrix accepted afterwards yields fresh (cleared) results.
- Overflow, N=2, DW=16, AW=32: 3 beats of all 32767*32767. Expect the wrapped value without the macro, and 2147483647 on every element with SYSTOLIC_SATURATE_EN.
- Reset mid-operation: assert rst during DRAIN. Expect busy=0, in_ready=1 and out_valid=0 immediately, no result rows emitted, and a following matrix computes correctly.
